// File: rtl/conv_out_serializer_if.sv
// Handshake bundle for conv_out_serializer: frame input stream and set-bit address output stream.
interface conv_out_serializer_if #(
    parameter int ch_out               = 128,
    parameter int stream_out_add_width = $clog2(ch_out)
) ();
    logic [ch_out-1:0]               stream_in;
    logic                            stream_in_en;
    logic                            stream_in_ready;
    logic [stream_out_add_width-1:0] stream_out_add;
    logic                            stream_out_en;
    logic                            stream_out_ready;
    logic                            stream_out_last;

    // Serializer side
    modport slave (
        input  stream_in, stream_in_en, stream_out_ready,
        output stream_in_ready, stream_out_add, stream_out_en, stream_out_last
    );

    // Frame producer / beat consumer side
    modport master (
        output stream_in, stream_in_en, stream_out_ready,
        input  stream_in_ready, stream_out_add, stream_out_en, stream_out_last
    );
endinterface

// File: rtl/conv_out_serializer.sv
// Captures a ch_out-bit frame and emits the index of each set bit, lowest first, one per accepted beat.
module conv_out_serializer #(
    parameter int ch_out               = 128,
    parameter int stream_out_add_width = $clog2(ch_out),
    parameter int count_width          = $clog2(ch_out) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_out_serializer_if.slave   bus,
    output logic                   frame_empty,
    output logic [count_width-1:0] frame_count
);
    localparam int unsigned CW = ch_out;
    localparam int unsigned AW = stream_out_add_width;
    localparam int unsigned NW = count_width;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   shadow_q, shadow_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   fcount_q, fcount_d;
    logic            fempty_q, fempty_d;
    logic            out_en_q, out_en_d;
    logic [AW-1:0]   add_q, add_d;
    logic            last_q, last_d;
    logic            in_ready_q, in_ready_d;
    logic [AW-1:0]   lsb_idx;
    logic            one_hot;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            cnt_q      <= '0;
            fcount_q   <= '0;
            fempty_q   <= 1'b0;
            out_en_q   <= 1'b0;
            add_q      <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            fcount_q   <= fcount_d;
            fempty_q   <= fempty_d;
            out_en_q   <= out_en_d;
            add_q      <= add_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state: capture in IDLE, clear one bit per accepted beat in SCAN
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        fcount_d = fcount_q;
        fempty_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.stream_in_en) begin
                    if (bus.stream_in != '0) begin
                        shadow_d = bus.stream_in;
                        cnt_d    = '0;
                        state_d  = SCAN;
                    end else begin
                        fempty_d = 1'b1;
                        fcount_d = '0;
                    end
                end
            end
            SCAN: begin
                if (bus.stream_out_ready) begin
                    shadow_d = shadow_q & ~(CW'(1) << add_q);
                    cnt_d    = cnt_q + NW'(1);
                    if (last_q) begin
                        fcount_d = cnt_q + NW'(1);
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register inputs decoded from next-cycle shadow so beats stay registered
    always_comb begin
        lsb_idx = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            if (shadow_d[i]) lsb_idx = AW'(i);
        end
        one_hot    = (shadow_d != '0) && ((shadow_d & (shadow_d - CW'(1))) == '0);
        out_en_d   = (state_d == SCAN);
        add_d      = out_en_d ? lsb_idx : '0;
        last_d     = out_en_d && one_hot;
        in_ready_d = (state_d == IDLE);
    end

    assign bus.stream_in_ready = in_ready_q;
    assign bus.stream_out_en   = out_en_q;
    assign bus.stream_out_add  = add_q;
    assign bus.stream_out_last = last_q;
    assign frame_empty         = fempty_q;
    assign frame_count         = fcount_q;
endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed bench for conv_out_serializer with ch_out=8 and hand-computed beat sequences.
module tb_conv_out_serializer;
    localparam int CH = 8;
    localparam int AW = $clog2(CH);
    localparam int NW = $clog2(CH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_empty;
    logic [NW-1:0] frame_count;
    int            total = 0;
    int            bad   = 0;

    conv_out_serializer_if #(.ch_out(CH), .stream_out_add_width(AW)) bus ();

    conv_out_serializer #(.ch_out(CH), .stream_out_add_width(AW), .count_width(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .frame_empty(frame_empty),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int en, input int add, input int last);
        check({tag, ".en"},   32'(bus.stream_out_en),   32'(en));
        check({tag, ".add"},  32'(bus.stream_out_add),  32'(add));
        check({tag, ".last"}, 32'(bus.stream_out_last), 32'(last));
    endtask

    task automatic capture(input logic [CH-1:0] v);
        bus.stream_in    = v;
        bus.stream_in_en = 1'b1;
        tick();
        bus.stream_in_en = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        bus.stream_in        = '0;
        bus.stream_in_en     = 1'b0;
        bus.stream_out_ready = 1'b1;
        #12;
        beat("rst", 0, 0, 0);
        check("rst.ready", 32'(bus.stream_in_ready), 1);
        check("rst.fcount", 32'(frame_count), 0);
        check("rst.fempty", 32'(frame_empty), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1010_0100: beats 2,5,7
        capture(8'b1010_0100);
        beat("a4.b0", 1, 2, 0);
        check("a4.ready", 32'(bus.stream_in_ready), 0);
        tick();
        beat("a4.b1", 1, 5, 0);
        tick();
        beat("a4.b2", 1, 7, 1);
        tick();
        check("a4.idle", 32'(bus.stream_in_ready), 1);
        check("a4.en", 32'(bus.stream_out_en), 0);
        check("a4.fcount", 32'(frame_count), 3);

        // All-zero frame
        capture(8'h00);
        check("z.en", 32'(bus.stream_out_en), 0);
        check("z.fempty", 32'(frame_empty), 1);
        check("z.fcount", 32'(frame_count), 0);
        check("z.ready", 32'(bus.stream_in_ready), 1);
        tick();
        check("z.fempty2", 32'(frame_empty), 0);
        check("z.en2", 32'(bus.stream_out_en), 0);

        // Backpressure: 0000_0011 with ready low 3 cycles
        bus.stream_out_ready = 1'b0;
        capture(8'b0000_0011);
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("bp.hold%0d", i), 1, 0, 0);
            tick();
        end
        bus.stream_out_ready = 1'b1;
        beat("bp.b0", 1, 0, 0);
        tick();
        beat("bp.b1", 1, 1, 1);
        tick();
        check("bp.en", 32'(bus.stream_out_en), 0);
        check("bp.fcount", 32'(frame_count), 2);
        check("bp.fempty", 32'(frame_empty), 0);

        // All-ones frame
        capture(8'hFF);
        for (int i = 0; i < CH; i++) begin
            beat($sformatf("ff.b%0d", i), 1, i, (i == CH - 1) ? 1 : 0);
            tick();
        end
        check("ff.en", 32'(bus.stream_out_en), 0);
        check("ff.fcount", 32'(frame_count), 8);

        // Capture attempt during SCAN and on the last-beat edge is ignored
        capture(8'h80);
        beat("ign.b0", 1, 7, 1);
        bus.stream_in    = 8'h0F;
        bus.stream_in_en = 1'b1;
        tick();
        check("ign.en", 32'(bus.stream_out_en), 0);
        check("ign.ready", 32'(bus.stream_in_ready), 1);
        check("ign.fcount", 32'(frame_count), 1);
        bus.stream_in_en = 1'b0;
        tick();
        check("ign.en2", 32'(bus.stream_out_en), 0);

        // Mid-frame reset
        capture(8'h81);
        beat("mr.b0", 1, 0, 0);
        tick();
        beat("mr.b1", 1, 7, 1);
        reset = 1'b1;
        #1;
        beat("mr.rst", 0, 0, 0);
        check("mr.ready", 32'(bus.stream_in_ready), 1);
        check("mr.fcount", 32'(frame_count), 0);
        check("mr.fempty", 32'(frame_empty), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr.quiet%0d", i), 32'(bus.stream_out_en), 0);
        end
        check("mr.fcount2", 32'(frame_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
